// File: rtl/i2s_pkg.sv
// Shared constants for the I2S slave transmitter: word width, channel-mapping
// encodings and synchroniser depth.
package i2s_pkg;
  localparam int WORD_W_DEF   = 16;
  localparam int LR_LEFT_ONLY = 0;
  localparam int LR_DUAL_MONO = 1;
  localparam int LR_STEREO    = 2;
  localparam int SYNC_STAGES  = 2;

  typedef enum logic {
    SLOT_L = 1'b0,
    SLOT_R = 1'b1
  } slot_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output and occupancy count.
module sync_fifo #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        din,
  output logic [WORD_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // A full FIFO still takes a write when the same clk frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/i2s_slave_tx.sv
// Clock-slave Philips I2S transmitter: oversamples external sck/ws on clk and
// shifts buffered samples out MSB first, one sck after each ws transition.
module i2s_slave_tx
  import i2s_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int DEPTH   = 4,
  parameter int LR_MODE = LR_LEFT_ONLY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sck_in,
  input  logic                   ws_in,
  output logic                   sd_out,
  input  logic                   tx_en,
  input  logic [WORD_W-1:0]      sample_in,
  input  logic                   sample_vld,
  output logic                   sample_rdy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun
);
  localparam int CW = $clog2(WORD_W + 1);

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync;
  logic                   sck_s, sck_p, ws_s, rise, fall;
  logic                   ws_r, pending, started, en_frame, rdy_en;
  slot_e                  slot_r;
  logic [WORD_W-1:0]      shreg, copy, head, load_word;
  logic [CW-1:0]          bits_left;
  logic                   load, is_left, slot_en, pop_req;
  logic                   push, pop, full, empty;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign ws_s  = ws_sync[SYNC_STAGES-1];
  assign rise  = sck_s && !sck_p;
  assign fall  = !sck_s && sck_p;

  // Valid/ready: a sample transfers on any clk where sample_vld && sample_rdy;
  // sample_rdy depends only on the registered level, never on sample_vld.
  assign sample_rdy = rdy_en && !full;
  assign push       = sample_vld && sample_rdy;
  assign pop        = pop_req && !empty;

  sync_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sample_in),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_p    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      sck_p    <= sck_s;
    end
  end

  // Nothing is sent until the first left slot has been seen since reset.
  always_comb begin
    load      = fall && pending;
    is_left   = (slot_r == SLOT_L);
    slot_en   = is_left ? tx_en : en_frame;
    pop_req   = 1'b0;
    load_word = '0;
    if (load && (started || is_left) && slot_en) begin
      case (LR_MODE)
        LR_LEFT_ONLY: pop_req = is_left;
        LR_DUAL_MONO: pop_req = is_left;
        default:      pop_req = 1'b1;
      endcase
      if (pop_req) load_word = empty ? '0 : head;
      else if (LR_MODE == LR_DUAL_MONO) load_word = copy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_r     <= 1'b0;
      pending  <= 1'b0;
      slot_r   <= SLOT_L;
      started  <= 1'b0;
      en_frame <= 1'b0;
      copy     <= '0;
      rdy_en   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      underrun <= pop_req && empty;
      if (rise) begin
        ws_r <= ws_s;
        if (ws_s != ws_r) begin
          pending <= 1'b1;
          slot_r  <= ws_s ? SLOT_R : SLOT_L;
        end
      end else if (load) begin
        pending <= 1'b0;
        if (is_left) begin
          started  <= 1'b1;
          en_frame <= tx_en;
          copy     <= load_word;
        end
      end
    end
  end

  // Past the last word bit the line idles at 0 until the next slot start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_out    <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
    end else if (load) begin
      sd_out    <= load_word[WORD_W-1];
      shreg     <= load_word << 1;
      bits_left <= CW'(WORD_W - 1);
    end else if (fall) begin
      if (bits_left != '0) begin
        sd_out    <= shreg[WORD_W-1];
        shreg     <= shreg << 1;
        bits_left <= bits_left - CW'(1);
      end else begin
        sd_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_slave_tx.sv
// Bench for i2s_slave_tx: one instance per channel mapping on a shared bus,
// each received slot compared against a frame-level model of the link.
module tb_i2s_slave_tx;
  localparam int W = 16;
  localparam int NM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic ws = 1'b0;
  logic tx_en = 1'b0;
  logic [W-1:0] sample_in [NM];
  logic sample_vld [NM];
  logic sample_rdy [NM];
  logic sd_out [NM];
  logic [2:0] fifo_level [NM];
  logic underrun [NM];

  logic [W-1:0] exp_q [NM][$];
  logic [W-1:0] mq [NM][$];
  logic [W-1:0] cpy [NM];
  bit started [NM];
  bit en_f [NM];
  int exp_ur [NM];
  int ur_cnt [NM];
  int lens [4] = '{12, 16, 20, 32};
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    i2s_slave_tx #(.WORD_W(W), .DEPTH(4), .LR_MODE(g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sck_in     (sck),
      .ws_in      (ws),
      .sd_out     (sd_out[g]),
      .tx_en      (tx_en),
      .sample_in  (sample_in[g]),
      .sample_vld (sample_vld[g]),
      .sample_rdy (sample_rdy[g]),
      .fifo_level (fifo_level[g]),
      .underrun   (underrun[g])
    );
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Link model: what each slot must carry, decided when the slot starts.
  task automatic model_slot(bit side);
    logic [W-1:0] w;
    for (int m = 0; m < NM; m++) begin
      w = '0;
      if (side == 1'b0) begin
        started[m] = 1'b1;
        en_f[m] = tx_en;
      end
      if (started[m] && en_f[m]) begin
        if (side == 1'b0 || m == 2) begin
          if (mq[m].size() > 0) w = mq[m].pop_front();
          else exp_ur[m]++;
          if (m == 1) cpy[m] = w;
        end else if (m == 1) begin
          w = cpy[m];
        end
      end
      exp_q[m].push_back(w);
    end
  endtask

  task automatic finalize(int m, logic [63:0] act, int nb);
    logic [W-1:0] w;
    logic [63:0] e;
    logic [63:0] mask;
    check($sformatf("slot_expected_m%0d", m), 64'(exp_q[m].size() > 0), 64'd1);
    if (exp_q[m].size() > 0) begin
      w = exp_q[m].pop_front();
      e = '0;
      for (int i = 0; i < nb; i++) e = {e[62:0], (i < W) ? w[W-1-i] : 1'b0};
      mask = (64'd1 << nb) - 64'd1;
      check($sformatf("slot_bits_m%0d_n%0d", m, nb), act & mask, e);
    end
  endtask

  // Receiver: samples sd on sck rise; the bit on the first rise of a new ws
  // value is the last bit of the previous slot.
  initial begin : monitor
    logic ws_prev;
    bit open;
    int nb [NM];
    logic [63:0] bits [NM];
    ws_prev = 1'b0;
    open = 1'b0;
    for (int m = 0; m < NM; m++) begin nb[m] = 0; bits[m] = '0; end
    forever begin
      @(posedge sck or negedge rst_n);
      if (!rst_n) begin
        ws_prev = 1'b0;
        open = 1'b0;
        for (int m = 0; m < NM; m++) begin nb[m] = 0; bits[m] = '0; end
      end else begin
        for (int m = 0; m < NM; m++) begin
          bits[m] = {bits[m][62:0], sd_out[m]};
          nb[m]++;
        end
        if (ws !== ws_prev) begin
          if (open) for (int m = 0; m < NM; m++) finalize(m, bits[m], nb[m]);
          open = 1'b1;
          for (int m = 0; m < NM; m++) begin nb[m] = 0; bits[m] = '0; end
        end
        ws_prev = ws;
      end
    end
  end

  initial begin : underrun_counter
    forever begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        if (!rst_n) ur_cnt[m] = 0;
        else if (underrun[m]) ur_cnt[m]++;
      end
    end
  end

  task automatic half_sck();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    sck = 1'b0;
    ws = 1'b0;
    for (int m = 0; m < NM; m++) sample_vld[m] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < NM; m++) begin
      check($sformatf("rst_sd_m%0d", m), 64'(sd_out[m]), 64'd0);
      check($sformatf("rst_level_m%0d", m), 64'(fifo_level[m]), 64'd0);
      check($sformatf("rst_rdy_m%0d", m), 64'(sample_rdy[m]), 64'd0);
      check($sformatf("rst_underrun_m%0d", m), 64'(underrun[m]), 64'd0);
      exp_q[m].delete();
      mq[m].delete();
      started[m] = 1'b0;
      en_f[m] = 1'b0;
      cpy[m] = '0;
      exp_ur[m] = 0;
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int m = 0; m < NM; m++)
      check($sformatf("rdy_at_release_m%0d", m), 64'(sample_rdy[m]), 64'd0);
    @(posedge clk);
    #1;
    for (int m = 0; m < NM; m++)
      check($sformatf("rdy_after_release_m%0d", m), 64'(sample_rdy[m]), 64'd1);
    @(negedge clk);
  endtask

  task automatic push(int m, logic [W-1:0] v);
    int budget;
    budget = 0;
    @(negedge clk);
    sample_in[m] = v;
    sample_vld[m] = 1'b1;
    while (!sample_rdy[m] && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check($sformatf("push_rdy_m%0d", m), 64'(sample_rdy[m]), 64'd1);
    if (sample_rdy[m]) mq[m].push_back(v);
    @(posedge clk);
    #1 sample_vld[m] = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_all(logic [W-1:0] v);
    for (int m = 0; m < NM; m++) if (mq[m].size() < 4) push(m, v);
  endtask

  task automatic check_level();
    for (int m = 0; m < NM; m++) begin
      check($sformatf("level_m%0d", m), 64'(fifo_level[m]), 64'(mq[m].size()));
      check($sformatf("rdy_m%0d", m), 64'(sample_rdy[m]), 64'(mq[m].size() != 4));
    end
  endtask

  task automatic slot(bit side, int n, int drop_at = -1);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      if (i == 0) begin
        ws = side;
        model_slot(side);
      end
      if (i == drop_at) tx_en = 1'b0;
      half_sck();
      sck = 1'b1;
      half_sck();
    end
    check_level();
  endtask

  task automatic frame(int n, int drop_at = -1);
    slot(1'b0, n, drop_at);
    slot(1'b1, n);
  endtask

  task automatic check_underruns();
    for (int m = 0; m < NM; m++)
      check($sformatf("underrun_count_m%0d", m), 64'(ur_cnt[m]), 64'(exp_ur[m]));
  endtask

  // One extra ws edge so the receiver closes the last real slot.
  task automatic close_phase();
    sck = 1'b0;
    ws = ~ws;
    half_sck();
    sck = 1'b1;
    half_sck();
    for (int m = 0; m < NM; m++)
      check($sformatf("slots_drained_m%0d", m), 64'(exp_q[m].size()), 64'd0);
    check_underruns();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    for (int m = 0; m < NM; m++) begin
      sample_in[m] = '0;
      sample_vld[m] = 1'b0;
    end
    @(negedge clk);

    // Basic transfer
    do_reset();
    push_all(16'hA5C3);
    push_all(16'h7FFF);
    tx_en = 1'b1;
    slot(1'b1, 16);
    repeat (3) frame(16);
    close_phase();

    // Underrun on an empty FIFO, then recovery
    do_reset();
    tx_en = 1'b1;
    slot(1'b1, 16);
    repeat (3) frame(16);
    check_underruns();
    push_all(16'h8000);
    frame(16);
    close_phase();

    // Stereo sequence
    do_reset();
    push_all(16'h0001);
    push_all(16'hFFFE);
    push_all(16'h1234);
    push_all(16'h4321);
    tx_en = 1'b1;
    slot(1'b1, 16);
    repeat (3) frame(16);
    close_phase();

    // Backpressure with sck stopped
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int m = 0; m < NM; m++) begin
        sample_in[m] = W'($urandom);
        sample_vld[m] = 1'b1;
        if (sample_rdy[m]) mq[m].push_back(sample_in[m]);
      end
      @(negedge clk);
    end
    for (int m = 0; m < NM; m++) sample_vld[m] = 1'b0;
    for (int m = 0; m < NM; m++) begin
      check($sformatf("full_rdy_m%0d", m), 64'(sample_rdy[m]), 64'd0);
      check($sformatf("full_level_m%0d", m), 64'(fifo_level[m]), 64'd4);
    end
    tx_en = 1'b1;
    slot(1'b1, 16);
    repeat (2) frame(16);
    close_phase();

    // Enable dropped mid-left-slot, then a disabled frame, then re-enabled
    do_reset();
    push_all(16'h1357);
    tx_en = 1'b1;
    slot(1'b1, 16);
    frame(16, 6);
    frame(16);
    tx_en = 1'b1;
    push_all(16'h2468);
    frame(16);
    close_phase();

    // Reset mid-word, then 12-sck slots truncating each word
    do_reset();
    push_all(16'hF0F0);
    push_all(16'h0F0F);
    tx_en = 1'b1;
    slot(1'b1, 16);
    slot(1'b0, 6);
    do_reset();
    push_all(16'hABCD);
    push_all(16'h9876);
    push_all(16'h55AA);
    tx_en = 1'b1;
    slot(1'b1, 12);
    repeat (3) frame(12);
    close_phase();

    // Randomised slot lengths, data and enables
    for (int r = 0; r < 4; r++) begin
      int n;
      int k;
      do_reset();
      n = lens[$urandom_range(0, 3)];
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) push_all(W'($urandom));
      tx_en = 1'b1;
      slot(1'b1, n);
      for (int f = 0; f < 3; f++) begin
        tx_en = ($urandom_range(0, 3) != 0);
        frame(n);
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) push_all(W'($urandom));
      end
      close_phase();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
